t05_hist_sram_arb: RTL and testbench
====================================

Name: t05_hist_sram_arb

Overview:
Owns the single-port 256x32 histogram SRAM and shares it between two requesters. Port H is the histogram updater, which performs read-modify-write per input byte. Port C is the downstream consumer (min-finder / tree builder), which scans counts and may write them back. The block also sequences a full-memory clear after reset and on demand, so histogram accumulation always starts from zero.

Parameters:
RD_LAT, 2, SRAM read latency in cycles from read command to valid mem_rdata (1..4)
DEPTH, 256, entries cleared by the clear sequence (address width fixed at 8)

Ports:
clk  in  1  system clock
rst  in  1  reset
clr_start  in  1  pulse: request full clear
clr_busy  out  1  high while clearing
clr_done  out  1  one-cycle pulse when clear completes
h_req / c_req  in  1  access request; req, we, addr, wdata and lock held stable until gnt
h_we / c_we  in  1  1=write, 0=read
h_lock / c_lock  in  1  hold ownership after this access
h_addr / c_addr  in  8  entry address
h_wdata / c_wdata  in  32  write data
h_gnt / c_gnt  out  1  one-cycle pulse: command issued to SRAM
h_rvalid / c_rvalid  out  1  one-cycle pulse: rdata valid for that port
rdata  out  32  shared read data, qualified by *_rvalid
mem_wr_r_en  out  2  SRAM command: 0=read, 1=write, 3=idle
mem_addr  out  8  SRAM address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data

Behaviour:
- Clocking and reset: single clock clk. rst is synchronous and active-high.
- Reset values: all outputs 0 except mem_wr_r_en=3. lock_owner=none, rr_last=C (H wins first tie). State=CLEAR with clear counter=0.
- All outputs are registered.
- States: CLEAR, ARB, RWAIT.
- CLEAR:
  - clr_busy=1.
  - Each cycle issues mem_wr_r_en=1, mem_wdata=0, mem_addr=counter, then increments the counter.
  - After address DEPTH-1 (DEPTH cycles total): clr_done pulses in the next cycle and the block goes to ARB.
  - No grants are issued in CLEAR. clr_start arriving in CLEAR is ignored.
- ARB, priority order:
  - (1) clr_start: clears lock_owner and the counter, goes to CLEAR. Requests stay pending.
  - (2) lock_owner set: only the owner's request can be granted; the other port waits.
  - (3) Both requesting: grant the port that is not rr_last.
  - (4) Single request: grant it.
- Grant timing: if a request is sampled in ARB at cycle t, then in cycle t+1 mem_* carries the command and gnt=1 for that port. rr_last becomes the granted port.
  - Lock update on grant: lock=1 sets lock_owner to that port; lock=0 from the owner clears it.
- Write grant: returns to ARB at t+1, so the next command can issue at t+2. Back-to-back writes from one port are therefore 1 per 2 cycles.
- Read grant: goes to RWAIT.
  - mem_rdata is sampled in cycle t+1+RD_LAT.
  - rdata and the owner's rvalid are driven in cycle t+2+RD_LAT.
  - Returns to ARB in that same cycle.
  - mem_wr_r_en=3 throughout RWAIT.
- clr_start during RWAIT: latched as pending, then taken in ARB after the rvalid cycle. The in-flight read always completes.
- Outside issue cycles, mem_wr_r_en=3 and mem_addr/mem_wdata hold their last values.
- rdata holds its value until the next read return.
- gnt and rvalid never assert for both ports in the same cycle.
- Requester contract: dropping req before gnt is legal, and nothing is issued for it. The lock field of a dropped request is ignored.
- rst asserted mid-transaction (any state) aborts it: no rvalid is produced and the clear restarts from address 0.

Test Plan:
- Reset → clr_busy=1 for 256 cycles; mem writes of 0 to addresses 0x00..0xFF in order; clr_done pulses once; no gnt during the clear.
- After clear, H reads 0x41 with RD_LAT=2 and mem_rdata=7 → h_gnt at t+1, mem_wr_r_en=0, h_rvalid with rdata=7 at t+4, c_rvalid stays 0.
- H and C both request continuously, writes, no lock → grants alternate H,C,H,C, starting with H.
- H read with lock=1 to 0x10, then H write 8 to 0x10 with lock=0 while C requests throughout → C is not granted until the cycle after the H write gnt.
- clr_start pulsed during an H read's RWAIT → h_rvalid still delivered; CLEAR starts the cycle after; lock cleared; pending C request granted only after clr_done.
- rst asserted mid-RWAIT → no rvalid; mem_wr_r_en begins writing 0 to 0x00 on the next cycle.

Source files
------------

// File: rtl/t05_hist_sram_arb_if.sv
// Bus bundle between the histogram SRAM arbiter and its two requesters,
// the clear controller and the SRAM macro.
interface t05_hist_sram_arb_if;
   logic        clr_start;
   logic        clr_busy;
   logic        clr_done;
   logic        h_req;
   logic        h_we;
   logic        h_lock;
   logic [7:0]  h_addr;
   logic [31:0] h_wdata;
   logic        h_gnt;
   logic        h_rvalid;
   logic        c_req;
   logic        c_we;
   logic        c_lock;
   logic [7:0]  c_addr;
   logic [31:0] c_wdata;
   logic        c_gnt;
   logic        c_rvalid;
   logic [31:0] rdata;
   logic [1:0]  mem_wr_r_en;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  clr_start, h_req, h_we, h_lock, h_addr, h_wdata,
             c_req, c_we, c_lock, c_addr, c_wdata, mem_rdata,
      output clr_busy, clr_done, h_gnt, h_rvalid, c_gnt, c_rvalid,
             rdata, mem_wr_r_en, mem_addr, mem_wdata
   );

   modport master (
      output clr_start, h_req, h_we, h_lock, h_addr, h_wdata,
             c_req, c_we, c_lock, c_addr, c_wdata, mem_rdata,
      input  clr_busy, clr_done, h_gnt, h_rvalid, c_gnt, c_rvalid,
             rdata, mem_wr_r_en, mem_addr, mem_wdata
   );
endinterface

// File: rtl/t05_hist_sram_arb.sv
// Single-port histogram SRAM owner: clears the memory after reset or on demand,
// then arbitrates round-robin (with optional lock) between updater H and consumer C.
module t05_hist_sram_arb #(
   parameter int RD_LAT = 2,
   parameter int DEPTH  = 256
) (
   input logic                 clk,
   input logic                 rst,
   t05_hist_sram_arb_if.slave  bus
);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {S_CLEAR, S_ARB, S_RWAIT} state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_H    = 2'd1;
   localparam logic [1:0] OWN_C    = 2'd2;
   localparam logic [1:0] CMD_WR   = 2'd1;
   localparam logic [1:0] CMD_IDLE = 2'd3;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    wcnt, wcnt_nxt;
   logic [1:0]    lock_owner, lock_nxt;
   logic          rr_last_c, rr_nxt;
   logic          rd_is_c, rd_is_c_nxt;
   logic          clr_pend, clr_pend_nxt;
   logic          busy_nxt, done_nxt;
   logic          h_gnt_nxt, c_gnt_nxt, h_rv_nxt, c_rv_nxt;
   logic [31:0]   rdata_nxt, wdata_nxt;
   logic [1:0]    cmd_nxt;
   logic [7:0]    addr_nxt;
   logic          hr, cr, pick_h, pick_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_CLEAR;
         cnt             <= '0;
         wcnt            <= '0;
         lock_owner      <= OWN_NONE;
         rr_last_c       <= 1'b1;
         rd_is_c         <= 1'b0;
         clr_pend        <= 1'b0;
         bus.clr_busy    <= 1'b0;
         bus.clr_done    <= 1'b0;
         bus.h_gnt       <= 1'b0;
         bus.c_gnt       <= 1'b0;
         bus.h_rvalid    <= 1'b0;
         bus.c_rvalid    <= 1'b0;
         bus.rdata       <= '0;
         bus.mem_wr_r_en <= CMD_IDLE;
         bus.mem_addr    <= '0;
         bus.mem_wdata   <= '0;
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         wcnt            <= wcnt_nxt;
         lock_owner      <= lock_nxt;
         rr_last_c       <= rr_nxt;
         rd_is_c         <= rd_is_c_nxt;
         clr_pend        <= clr_pend_nxt;
         bus.clr_busy    <= busy_nxt;
         bus.clr_done    <= done_nxt;
         bus.h_gnt       <= h_gnt_nxt;
         bus.c_gnt       <= c_gnt_nxt;
         bus.h_rvalid    <= h_rv_nxt;
         bus.c_rvalid    <= c_rv_nxt;
         bus.rdata       <= rdata_nxt;
         bus.mem_wr_r_en <= cmd_nxt;
         bus.mem_addr    <= addr_nxt;
         bus.mem_wdata   <= wdata_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      wcnt_nxt     = wcnt;
      lock_nxt     = lock_owner;
      rr_nxt       = rr_last_c;
      rd_is_c_nxt  = rd_is_c;
      clr_pend_nxt = clr_pend;
      busy_nxt     = 1'b0;
      done_nxt     = 1'b0;
      h_gnt_nxt    = 1'b0;
      c_gnt_nxt    = 1'b0;
      h_rv_nxt     = 1'b0;
      c_rv_nxt     = 1'b0;
      rdata_nxt    = bus.rdata;
      cmd_nxt      = CMD_IDLE;
      addr_nxt     = bus.mem_addr;
      wdata_nxt    = bus.mem_wdata;
      // A port whose grant is on the bus this cycle is still holding req; mask it.
      hr           = bus.h_req & ~bus.h_gnt & (lock_owner != OWN_C);
      cr           = bus.c_req & ~bus.c_gnt & (lock_owner != OWN_H);
      pick_h       = hr & (~cr | rr_last_c);
      pick_c       = cr & ~pick_h;

      case (state)
         S_CLEAR: begin
            clr_pend_nxt = 1'b0;
            if (cnt < CW'(DEPTH)) begin
               cmd_nxt   = CMD_WR;
               addr_nxt  = 8'(cnt);
               wdata_nxt = '0;
               busy_nxt  = 1'b1;
               cnt_nxt   = cnt + CW'(1);
            end else begin
               done_nxt  = 1'b1;
               state_nxt = S_ARB;
            end
         end
         S_ARB: begin
            if (bus.clr_start || clr_pend) begin
               // First clear write issues right away; the counter resumes at 1.
               clr_pend_nxt = 1'b0;
               lock_nxt     = OWN_NONE;
               cnt_nxt      = CW'(1);
               cmd_nxt      = CMD_WR;
               addr_nxt     = '0;
               wdata_nxt    = '0;
               busy_nxt     = 1'b1;
               state_nxt    = S_CLEAR;
            end else if (pick_h) begin
               h_gnt_nxt = 1'b1;
               cmd_nxt   = {1'b0, bus.h_we};
               addr_nxt  = bus.h_addr;
               wdata_nxt = bus.h_wdata;
               rr_nxt    = 1'b0;
               lock_nxt  = bus.h_lock ? OWN_H : OWN_NONE;
               if (!bus.h_we) begin
                  state_nxt   = S_RWAIT;
                  rd_is_c_nxt = 1'b0;
                  wcnt_nxt    = '0;
               end
            end else if (pick_c) begin
               c_gnt_nxt = 1'b1;
               cmd_nxt   = {1'b0, bus.c_we};
               addr_nxt  = bus.c_addr;
               wdata_nxt = bus.c_wdata;
               rr_nxt    = 1'b1;
               lock_nxt  = bus.c_lock ? OWN_C : OWN_NONE;
               if (!bus.c_we) begin
                  state_nxt   = S_RWAIT;
                  rd_is_c_nxt = 1'b1;
                  wcnt_nxt    = '0;
               end
            end
         end
         S_RWAIT: begin
            if (bus.clr_start) clr_pend_nxt = 1'b1;
            if (wcnt == 3'(RD_LAT)) begin
               rdata_nxt = bus.mem_rdata;
               h_rv_nxt  = ~rd_is_c;
               c_rv_nxt  = rd_is_c;
               state_nxt = S_ARB;
            end else begin
               wcnt_nxt = wcnt + 3'd1;
            end
         end
         default: state_nxt = S_CLEAR;
      endcase
   end
endmodule

// File: tb/tb_t05_hist_sram_arb.sv
// Directed bench for the histogram SRAM arbiter: clear sequence, read latency,
// round-robin, lock, clear-during-read and reset-during-read.
module tb_t05_hist_sram_arb;
   localparam int DEPTH = 256;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   t05_hist_sram_arb_if bus ();

   t05_hist_sram_arb #(.RD_LAT(2), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_check(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         chk({tag, "_cmd"},  32'(bus.mem_wr_r_en), 32'd1);
         chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(i));
         chk({tag, "_wd"},   bus.mem_wdata, 32'd0);
         chk({tag, "_busy"}, 32'(bus.clr_busy), 32'd1);
         chk({tag, "_gnt"},  32'({bus.h_gnt, bus.c_gnt}), 32'd0);
         chk({tag, "_done"}, 32'(bus.clr_done), 32'd0);
         step();
      end
      chk({tag, "_done_pulse"}, 32'(bus.clr_done), 32'd1);
      chk({tag, "_busy_end"},   32'(bus.clr_busy), 32'd0);
      chk({tag, "_cmd_end"},    32'(bus.mem_wr_r_en), 32'd3);
      chk({tag, "_gnt_end"},    32'({bus.h_gnt, bus.c_gnt}), 32'd0);
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b1;
      bus.clr_start = 1'b0;
      bus.h_req     = 1'b0; bus.h_we = 1'b0; bus.h_lock = 1'b0;
      bus.h_addr    = '0;   bus.h_wdata = '0;
      bus.c_req     = 1'b0; bus.c_we = 1'b0; bus.c_lock = 1'b0;
      bus.c_addr    = '0;   bus.c_wdata = '0;
      bus.mem_rdata = '0;
      step();
      step();
      chk("rst_cmd",   32'(bus.mem_wr_r_en), 32'd3);
      chk("rst_busy",  32'(bus.clr_busy), 32'd0);
      chk("rst_done",  32'(bus.clr_done), 32'd0);
      chk("rst_gnt",   32'({bus.h_gnt, bus.c_gnt}), 32'd0);
      chk("rst_rv",    32'({bus.h_rvalid, bus.c_rvalid}), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      rst = 1'b0;
      step();
      clear_check("boot");

      // Both ports writing continuously: H, C, H, C
      bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 8'h01; bus.h_wdata = 32'h11;
      bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 8'h02; bus.c_wdata = 32'h22;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("alt_h_gnt", 32'(bus.h_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("alt_c_gnt", 32'(bus.c_gnt), (k % 2 == 0) ? 32'd0 : 32'd1);
         chk("alt_addr",  32'(bus.mem_addr), (k % 2 == 0) ? 32'h01 : 32'h02);
         chk("alt_cmd",   32'(bus.mem_wr_r_en), 32'd1);
         chk("alt_done",  32'(bus.clr_done), 32'd0);
      end
      bus.h_req = 1'b0; bus.c_req = 1'b0;
      step();
      chk("idle_gnt",  32'({bus.h_gnt, bus.c_gnt}), 32'd0);
      chk("idle_cmd",  32'(bus.mem_wr_r_en), 32'd3);
      chk("idle_addr", 32'(bus.mem_addr), 32'h02);

      // H read of 0x41, RD_LAT=2
      bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 8'h41;
      bus.mem_rdata = 32'hdead;
      step();
      chk("rd_h_gnt", 32'(bus.h_gnt), 32'd1);
      chk("rd_c_gnt", 32'(bus.c_gnt), 32'd0);
      chk("rd_cmd",   32'(bus.mem_wr_r_en), 32'd0);
      chk("rd_addr",  32'(bus.mem_addr), 32'h41);
      bus.h_req = 1'b0;
      step();
      chk("rd_wait_cmd", 32'(bus.mem_wr_r_en), 32'd3);
      chk("rd_wait_rv2", 32'(bus.h_rvalid), 32'd0);
      step();
      chk("rd_wait_rv3", 32'(bus.h_rvalid), 32'd0);
      bus.mem_rdata = 32'd7;
      step();
      bus.mem_rdata = 32'hbeef;
      chk("rd_h_rv",   32'(bus.h_rvalid), 32'd1);
      chk("rd_c_rv",   32'(bus.c_rvalid), 32'd0);
      chk("rd_rdata",  bus.rdata, 32'd7);
      step();
      chk("rd_rv_off", 32'(bus.h_rvalid), 32'd0);
      chk("rd_hold",   bus.rdata, 32'd7);

      // Back-to-back H writes: one grant every other cycle
      bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 8'h05; bus.h_wdata = 32'h50;
      step(); chk("b2b_g0", 32'(bus.h_gnt), 32'd1);
      step(); chk("b2b_g1", 32'(bus.h_gnt), 32'd0);
      step(); chk("b2b_g2", 32'(bus.h_gnt), 32'd1);
      bus.h_req = 1'b0;
      step(); chk("b2b_g3", 32'(bus.h_gnt), 32'd0);

      // Locked read-modify-write by H while C waits
      bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_lock = 1'b1; bus.h_addr = 8'h10;
      bus.mem_rdata = 32'h0;
      step();
      chk("lk_rd_gnt", 32'(bus.h_gnt), 32'd1);
      bus.h_req = 1'b0; bus.h_lock = 1'b0;
      bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 8'h20; bus.c_wdata = 32'h99;
      step(); chk("lk_c_wait2", 32'(bus.c_gnt), 32'd0);
      step(); chk("lk_c_wait3", 32'(bus.c_gnt), 32'd0);
      bus.mem_rdata = 32'h1234;
      step();
      chk("lk_h_rv",    32'(bus.h_rvalid), 32'd1);
      chk("lk_rdata",   bus.rdata, 32'h1234);
      chk("lk_c_wait4", 32'(bus.c_gnt), 32'd0);
      bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_lock = 1'b0; bus.h_addr = 8'h10; bus.h_wdata = 32'd8;
      step();
      chk("lk_wr_gnt",  32'(bus.h_gnt), 32'd1);
      chk("lk_c_wait5", 32'(bus.c_gnt), 32'd0);
      chk("lk_wr_cmd",  32'(bus.mem_wr_r_en), 32'd1);
      chk("lk_wr_addr", 32'(bus.mem_addr), 32'h10);
      chk("lk_wr_data", bus.mem_wdata, 32'd8);
      bus.h_req = 1'b0;
      step();
      chk("lk_c_gnt",  32'(bus.c_gnt), 32'd1);
      chk("lk_c_addr", 32'(bus.mem_addr), 32'h20);
      chk("lk_c_data", bus.mem_wdata, 32'h99);
      bus.c_req = 1'b0;
      step();

      // clr_start during H's locked read wait
      bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_lock = 1'b1; bus.h_addr = 8'h55;
      step();
      chk("cr_h_gnt", 32'(bus.h_gnt), 32'd1);
      bus.h_req = 1'b0; bus.h_lock = 1'b0;
      bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 8'h66; bus.c_wdata = 32'h77;
      bus.clr_start = 1'b1;
      step();
      bus.clr_start = 1'b0;
      chk("cr_c_wait2", 32'(bus.c_gnt), 32'd0);
      chk("cr_busy2",   32'(bus.clr_busy), 32'd0);
      step();
      chk("cr_c_wait3", 32'(bus.c_gnt), 32'd0);
      bus.mem_rdata = 32'habc;
      step();
      chk("cr_h_rv",  32'(bus.h_rvalid), 32'd1);
      chk("cr_rdata", bus.rdata, 32'habc);
      chk("cr_cmd",   32'(bus.mem_wr_r_en), 32'd3);
      chk("cr_c_rv",  32'(bus.c_gnt), 32'd0);
      step();
      clear_check("reclr");
      step();
      chk("cr_c_gnt",  32'(bus.c_gnt), 32'd1);
      chk("cr_c_addr", 32'(bus.mem_addr), 32'h66);
      chk("cr_c_data", bus.mem_wdata, 32'h77);
      bus.c_req = 1'b0;
      step();

      // Reset during a read wait aborts it
      bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 8'h77;
      step();
      chk("rr_h_gnt", 32'(bus.h_gnt), 32'd1);
      bus.h_req = 1'b0;
      step();
      rst = 1'b1;
      bus.mem_rdata = 32'h5a;
      step();
      chk("rr_cmd",   32'(bus.mem_wr_r_en), 32'd3);
      chk("rr_rdata", bus.rdata, 32'd0);
      chk("rr_rv",    32'(bus.h_rvalid), 32'd0);
      chk("rr_busy",  32'(bus.clr_busy), 32'd0);
      rst = 1'b0;
      step();
      chk("rr_no_rv", 32'(bus.h_rvalid), 32'd0);
      clear_check("rstclr");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
